rmt_match_router: RTL
=====================

// Module: rmt_match_router
// PURPOSE
//  Single-port AXI-Stream packet classifier/router, successor to the fixed-function match-action stage.
//  Checks each packet's first-beat header (ethertype + delimiter) and looks up the function code in a RULE_COUNT-entry runtime table to choose m_axis_tdest.
//  Packets failing the header check, or matching no rule when DROP_UNMATCHED=1, are consumed and discarded.
//  Sits between the MAC RX datapath and the app-side demux; a full-throughput, backpressure-correct replacement.
// PARAMETERS
//  DATA_WIDTH      512      tdata width (bits); must be >= (FUNC_OFFSET+2)*8
//  KEEP_WIDTH      DATA_WIDTH/8  tkeep width
//  USER_WIDTH      8        tuser width
//  DEST_WIDTH      2        tdest width
//  RULE_COUNT      4        match-table entries (1..16)
//  ETH_OFFSET      12       byte offset of ethertype in beat 0
//  DELIM_OFFSET    42       byte offset of delimiter in beat 0
//  FUNC_OFFSET     44       byte offset of function code in beat 0
//  ETH_VALUE       16'h0008 ethertype as it appears on tdata (0x0800, byte-swapped)
//  DELIM_VALUE     16'hF0E1 delimiter as it appears on tdata
//  DEFAULT_DEST    0        tdest used when no rule hits and DROP_UNMATCHED=0
//  DROP_UNMATCHED  0        1: discard header-valid packets that hit no rule
//  CNT_WIDTH       32       statistics counter width
// PORTS
//  clk            in   1                 clock; all logic on posedge
//  rst            in   1                 asynchronous, active-low reset
//  s_axis_tdata/tkeep/tvalid/tready/tlast/tuser   slave AXIS, widths per parameters (tready is an output)
//  m_axis_tdata/tkeep/tvalid/tready/tlast/tuser   master AXIS, widths per parameters (tready is an input)
//  m_axis_tdest   out  DEST_WIDTH        per-packet destination, constant across all beats of a packet
//  cfg_we         in   1                 rule write strobe
//  cfg_idx        in   $clog2(RULE_COUNT) rule index
//  cfg_valid      in   1                 rule enable
//  cfg_func       in   16                function code to match (tdata byte order)
//  cfg_dest       in   DEST_WIDTH        destination on hit
//  stat_fwd       out  CNT_WIDTH         forwarded packets (counted on tlast beat)
//  stat_drop      out  CNT_WIDTH         dropped packets (counted on tlast beat)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; m_axis_tvalid=0; s_axis_tready=0; tdata/tkeep/tlast/tuser/tdest=0;
//   all rule valid bits=0; stat_* = 0. First cycle after release: s_axis_tready=1.
//  FSM states: IDLE, FWD, DROP. Classification uses beat 0 only (beat accepted in IDLE).
//   IDLE: hdr_ok = eth==ETH_VALUE && delim==DELIM_VALUE. Hit = lowest index i with valid[i] && func==cfg_func[i].
//    Forward when hdr_ok && (hit || !DROP_UNMATCHED); tdest = hit ? dest[i] : DEFAULT_DEST, latched into dest_reg.
//    Forward with !tlast -> FWD; forward with tlast -> stay IDLE. Otherwise drop: !tlast -> DROP, tlast -> IDLE.
//   FWD: every accepted beat is forwarded with dest_reg; tlast -> IDLE.
//   DROP: s_axis_tready held 1 (sink); beats discarded; tlast -> IDLE.
//  Output path: two-entry skid register (sub-module). One-cycle latency input-accept -> m_axis_tvalid.
//   s_axis_tready is registered: high while the skid has a free entry; full throughput at tready=1.
//   Once m_axis_tvalid=1, payload and tdest stay stable until m_axis_tready=1 (AXIS rule).
//  Beat loss and duplication are forbidden under any tready pattern.
//  Rule writes: a rule write takes effect on the cycle after cfg_we. A beat 0 accepted in the same cycle as
//   cfg_we uses the old table. In-flight packets keep their latched dest_reg.
//  Counters: saturate at all-ones and do not wrap. Fwd and drop never increment in the same cycle.
//  Single-beat packet: classified and completed in IDLE, counted the same cycle.
//  Reset asserted mid-packet: the packet is abandoned with no output tlast. Bench must treat downstream as flushed.
// STRUCTURE
//  Package rmt_pkg: state localparams (IDLE/FWD/DROP), default offset/value constants, rule struct field widths.
//  Sub-module axis_skid_reg (DATA+KEEP+LAST+USER+DEST bundled, 2 entries, registered ready, async active-low rst).
//  Top: header extraction, priority rule match (for-loop, lowest index wins), FSM, counters.
// TESTING
//  1 Reset release, rules empty, DROP_UNMATCHED=0: 3-beat pkt eth=0008 delim=F0E1 func=0001 -> 3 beats out, tdest=0, stat_fwd=1.
//  2 Rule0={1,0001,dest 1}, Rule2={1,0001,dest 3}: same pkt -> tdest=1 on all beats (lowest index wins).
//  3 eth=0608 4-beat pkt, then a valid pkt back-to-back -> first dropped (stat_drop=1), second forwarded intact.
//  4 Random m_axis_tready (50%) over 200 mixed pkts -> scoreboard has zero loss/dup, tdest stable while tvalid&&!tready.
//  5 DROP_UNMATCHED=1, func=0009 with no rule -> dropped. cfg_we in the cycle of beat 0 -> old table applied.
//  6 rst low mid-FWD -> all outputs 0 within same cycle, rules cleared, next pkt classified from IDLE.

Source files
------------

// File: rtl/rmt_match_router_pkg.sv
// Shared types and default header constants for the match router.
// Header offsets are byte positions within the first beat of a packet.
package rmt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam int          DEF_ETH_OFFSET   = 12;
    localparam int          DEF_DELIM_OFFSET = 42;
    localparam int          DEF_FUNC_OFFSET  = 44;
    localparam logic [15:0] DEF_ETH_VALUE    = 16'h0008;
    localparam logic [15:0] DEF_DELIM_VALUE  = 16'hF0E1;

    localparam int          FUNC_WIDTH       = 16;

endpackage

// File: rtl/rmt_match_router_skid.sv
// Two-entry output register for a bundled AXI-Stream payload.
// Ready is a flop; it looks ahead at the next occupancy so a single free slot keeps full rate.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] spare_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             ready_reg;
    logic             valid_reg;
    logic             push;
    logic             pop;

    assign push = in_valid && ready_reg;
    assign pop  = valid_reg && out_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            spare_reg <= '0;
            count_reg <= 2'd0;
            ready_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != 2'd2);
            valid_reg <= (count_next != 2'd0);
            case (count_reg)
                2'd0: begin
                    if (push) head_reg <= in_data;
                end
                2'd1: begin
                    if (push && pop) begin
                        head_reg <= in_data;
                    end else if (push) begin
                        spare_reg <= in_data;
                    end
                end
                default: begin
                    // Full: ready is already low, so only a pop can happen.
                    if (pop) head_reg <= spare_reg;
                end
            endcase
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = valid_reg;
    assign out_data  = head_reg;

endmodule

// File: rtl/rmt_match_router.sv
// AXI-Stream classifier: checks the first-beat header, matches the function code against a
// runtime rule table and forwards the packet with a per-packet tdest, or sinks it.
module rmt_match_router
    import rmt_pkg::*;
#(
    parameter int          DATA_WIDTH     = 512,
    parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int          USER_WIDTH     = 8,
    parameter int          DEST_WIDTH     = 2,
    parameter int          RULE_COUNT     = 4,
    parameter int          ETH_OFFSET     = DEF_ETH_OFFSET,
    parameter int          DELIM_OFFSET   = DEF_DELIM_OFFSET,
    parameter int          FUNC_OFFSET    = DEF_FUNC_OFFSET,
    parameter logic [15:0] ETH_VALUE      = DEF_ETH_VALUE,
    parameter logic [15:0] DELIM_VALUE    = DEF_DELIM_VALUE,
    parameter int          DEFAULT_DEST   = 0,
    parameter bit          DROP_UNMATCHED = 1'b0,
    parameter int          CNT_WIDTH      = 32,
    localparam int         IDX_WIDTH      = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,

    input  logic                  cfg_we,
    input  logic [IDX_WIDTH-1:0]  cfg_idx,
    input  logic                  cfg_valid,
    input  logic [FUNC_WIDTH-1:0] cfg_func,
    input  logic [DEST_WIDTH-1:0] cfg_dest,

    output logic [CNT_WIDTH-1:0]  stat_fwd,
    output logic [CNT_WIDTH-1:0]  stat_drop
);

    localparam int SKID_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;

    state_t                  state_reg;
    logic [DEST_WIDTH-1:0]   dest_reg;
    logic [CNT_WIDTH-1:0]    stat_fwd_reg;
    logic [CNT_WIDTH-1:0]    stat_drop_reg;

    logic                    rule_valid_reg [RULE_COUNT];
    logic [FUNC_WIDTH-1:0]   rule_func_reg  [RULE_COUNT];
    logic [DEST_WIDTH-1:0]   rule_dest_reg  [RULE_COUNT];
    logic [RULE_COUNT-1:0]   rule_hit;

    logic [15:0]             eth_field;
    logic [15:0]             delim_field;
    logic [FUNC_WIDTH-1:0]   func_field;
    logic                    hdr_ok;
    logic                    hit;
    logic [DEST_WIDTH-1:0]   hit_dest;
    logic [DEST_WIDTH-1:0]   beat_dest;
    logic                    fwd_now;
    logic                    fwd_beat;
    logic                    accept;

    logic                    skid_in_ready;
    logic                    skid_out_valid;
    logic [SKID_WIDTH-1:0]   skid_in_data;
    logic [SKID_WIDTH-1:0]   skid_out_data;
    logic [DEST_WIDTH-1:0]   skid_dest;

    assign eth_field   = s_axis_tdata[ETH_OFFSET*8 +: 16];
    assign delim_field = s_axis_tdata[DELIM_OFFSET*8 +: 16];
    assign func_field  = s_axis_tdata[FUNC_OFFSET*8 +: FUNC_WIDTH];
    assign hdr_ok      = (eth_field == ETH_VALUE) && (delim_field == DELIM_VALUE);

    genvar gi;
    generate
        for (gi = 0; gi < RULE_COUNT; gi++) begin : g_cmp
            assign rule_hit[gi] = rule_valid_reg[gi] && (rule_func_reg[gi] == func_field);
        end
    endgenerate

    // Walk from the top index down so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_dest = '0;
        for (int i = RULE_COUNT - 1; i >= 0; i--) begin
            if (rule_hit[i]) begin
                hit      = 1'b1;
                hit_dest = rule_dest_reg[i];
            end
        end
    end

    assign beat_dest = hit ? hit_dest : DEST_WIDTH'(DEFAULT_DEST);
    assign fwd_now   = hdr_ok && (hit || !DROP_UNMATCHED);
    assign fwd_beat  = ((state_reg == S_IDLE) && fwd_now) || (state_reg == S_FWD);
    assign skid_dest = (state_reg == S_IDLE) ? beat_dest : dest_reg;

    // While dropping, the input is a sink and never waits on the output side.
    assign s_axis_tready = (state_reg == S_DROP) || skid_in_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                rule_valid_reg[i] <= 1'b0;
                rule_func_reg[i]  <= '0;
                rule_dest_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                if (cfg_we && (cfg_idx == IDX_WIDTH'(i))) begin
                    rule_valid_reg[i] <= cfg_valid;
                    rule_func_reg[i]  <= cfg_func;
                    rule_dest_reg[i]  <= cfg_dest;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            dest_reg  <= '0;
        end else if (accept) begin
            case (state_reg)
                S_IDLE: begin
                    if (fwd_now) begin
                        dest_reg <= beat_dest;
                        if (!s_axis_tlast) state_reg <= S_FWD;
                    end else if (!s_axis_tlast) begin
                        state_reg <= S_DROP;
                    end
                end
                S_FWD, S_DROP: begin
                    if (s_axis_tlast) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fwd_reg  <= '0;
            stat_drop_reg <= '0;
        end else if (accept && s_axis_tlast) begin
            if (fwd_beat) begin
                if (stat_fwd_reg != '1) stat_fwd_reg <= stat_fwd_reg + CNT_WIDTH'(1);
            end else begin
                if (stat_drop_reg != '1) stat_drop_reg <= stat_drop_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign skid_in_data = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, skid_dest};

    axis_skid_reg #(
        .WIDTH (SKID_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (skid_in_data),
        .in_valid  (s_axis_tvalid && fwd_beat),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (skid_out_valid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = skid_out_data;
    assign m_axis_tvalid = skid_out_valid;
    assign stat_fwd      = stat_fwd_reg;
    assign stat_drop     = stat_drop_reg;

endmodule
